// File: rtl/arith_pkg.sv
// Shared definitions for the byte-serial arithmetic datapath.
package arith_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for n bytes; never below 1 so a single-byte build still
  // has a legal (if unused) index register.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/mb_add_seq_if.sv
// Operand/result bundle between the operand registers and the sequencer.
interface mb_add_seq_if
  import arith_pkg::*;
#(
  parameter int NBYTES = 4
);
  logic                     start;
  logic                     sub;
  logic [BYTE_W*NBYTES-1:0] a;
  logic [BYTE_W*NBYTES-1:0] b;
  logic                     busy;
  logic                     done;
  logic [BYTE_W*NBYTES-1:0] result;
  logic                     co;
  logic                     ovf;
  logic                     zero;

  modport master (output start, sub, a, b,
                  input  busy, done, result, co, ovf, zero);
  modport slave  (input  start, sub, a, b,
                  output busy, done, result, co, ovf, zero);
endinterface

// File: rtl/add8_slice.sv
// Combinational 8-bit ripple adder made of full-adder cells.
module add8_slice
  import arith_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);
  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    logic cy;
    cy = ci;
    s  = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    co = cy;
  end
endmodule

// File: rtl/mb_add_seq.sv
// Byte-serial add/subtract sequencer: one shared 8-bit slice, LSB first.
module mb_add_seq
  import arith_pkg::*;
#(
  parameter int NBYTES = 4
)(
  input  logic         clk,
  input  logic         rst_n,
  mb_add_seq_if.slave  bus
);
  localparam int              IDXW = clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  state_t                          state;
  logic [NBYTES-1:0][BYTE_W-1:0]   opa, opb, res, res_nxt;
  logic                            carry;
  logic [IDXW-1:0]                 idx;
  logic                            busy_q, done_q, co_q, ovf_q, zero_q;
  logic [BYTE_W-1:0]               sum;
  logic                            sum_co;

  add8_slice u_add (
    .a  (opa[idx]),
    .b  (opb[idx]),
    .ci (carry),
    .s  (sum),
    .co (sum_co)
  );

  // Result as it will look after this cycle's byte is written; lets the
  // zero flag be registered on the same edge as the final byte.
  always_comb begin
    res_nxt      = res;
    res_nxt[idx] = sum;
  end

  // Control FSM with operand, carry, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      opa    <= '0;
      opb    <= '0;
      res    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      co_q   <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            opa    <= bus.a;
            // Subtraction is A + ~B + 1: invert here, inject the +1 as
            // the byte-0 carry-in.
            opb    <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub;
            idx    <= '0;
            res    <= '0;
            co_q   <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          res[idx] <= sum;
          carry    <= sum_co;
          if (idx == LAST) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            co_q   <= sum_co;
            ovf_q  <= (opa[NBYTES-1][BYTE_W-1] == opb[NBYTES-1][BYTE_W-1]) &&
                      (sum[BYTE_W-1] != opa[NBYTES-1][BYTE_W-1]);
            zero_q <= (res_nxt == '0);
            state  <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res;
  assign bus.co     = co_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_mb_add_seq.sv
// Scoreboard bench for mb_add_seq at NBYTES=4.
module tb_mb_add_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mb_add_seq_if #(.NBYTES(NB)) bus();
  mb_add_seq #(.NBYTES(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [W-1:0] result;
    logic         co;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference: plain integer arithmetic plus a 33-bit signed range check.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub);
    exp_t       e;
    logic [W:0] s33;
    e.result = sub ? (a - b) : (a + b);
    e.co     = sub ? (a >= b) : (({1'b0, a} + {1'b0, b}) >> W) != 0;
    s33      = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
    e.ovf    = s33[W] != s33[W-1];
    e.zero   = (e.result == '0);
    return e;
  endfunction

  // Present an op for one edge; operands are scrambled afterwards.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = sub; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom);
  endtask

  // Called on the negedge after the start edge; bounded wait for done.
  task automatic wait_done(output int lat, output int busyc, output bit seen);
    lat = 0; busyc = 0; seen = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.done) begin
        seen = 1'b1;
        lat  = n - 1;
        break;
      end
      if (bus.busy) busyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    checks++; if (bus.co !== 1'b0) begin failures++; $display("FAIL reset_co got=%b exp=0", bus.co); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    checks++; if (bus.zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", bus.zero); end
  endtask

  task automatic test_op(input string name, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sub);
    int   lat, busyc;
    bit   seen;
    exp_t e;
    logic [W-1:0] held;
    sb.push_back(model(a, b, sub));
    start_op(a, b, sub);
    wait_done(lat, busyc, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout got=no_done exp=done", name);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checks++; if (lat != NB) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, NB); end
    checks++; if (busyc != NB) begin failures++; $display("FAIL %s_busycycles got=%0d exp=%0d", name, busyc, NB); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s_busy_at_done got=%b exp=0", name, bus.busy); end
    checks++; if (bus.result !== e.result) begin failures++; $display("FAIL %s_result got=%h exp=%h", name, bus.result, e.result); end
    checks++; if (bus.co !== e.co) begin failures++; $display("FAIL %s_co got=%b exp=%b", name, bus.co, e.co); end
    checks++; if (bus.ovf !== e.ovf) begin failures++; $display("FAIL %s_ovf got=%b exp=%b", name, bus.ovf, e.ovf); end
    checks++; if (bus.zero !== e.zero) begin failures++; $display("FAIL %s_zero got=%b exp=%b", name, bus.zero, e.zero); end
    held = e.result;
    repeat (2) @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL %s_done_pulse got=%b exp=0", name, bus.done); end
    checks++; if (bus.result !== held) begin failures++; $display("FAIL %s_result_held got=%h exp=%h", name, bus.result, held); end
  endtask

  task automatic test_ignore_start;
    int   lat, busyc, extra;
    bit   seen;
    exp_t e;
    sb.push_back(model(32'h1234_5678, 32'h0101_0101, 1'b0));
    start_op(32'h1234_5678, 32'h0101_0101, 1'b0);
    @(negedge clk);
    bus.a = 32'hDEAD_BEEF; bus.b = 32'h1111_1111; bus.sub = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, busyc, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ignore_timeout got=no_done exp=done");
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checks++; if (bus.result !== e.result) begin failures++; $display("FAIL ignore_result got=%h exp=%h", bus.result, e.result); end
    checks++; if (bus.co !== e.co) begin failures++; $display("FAIL ignore_co got=%b exp=%b", bus.co, e.co); end
    extra = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL ignore_extra_done got=%0d exp=0", extra); end
    checks++; if (bus.result !== e.result) begin failures++; $display("FAIL ignore_result_held got=%h exp=%h", bus.result, e.result); end
  endtask

  task automatic test_reset_mid_run;
    start_op(32'h0102_0304, 32'h0000_0010, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    checks++; if (bus.result !== '0) begin failures++; $display("FAIL midrst_result got=%h exp=0", bus.result); end
    checks++; if ({bus.co, bus.ovf, bus.zero} !== 3'b000) begin failures++; $display("FAIL midrst_flags got=%b exp=000", {bus.co, bus.ovf, bus.zero}); end
    @(negedge clk);
    rst_n = 1'b1;
    test_op("post_rst", 32'd3, 32'd4, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++)
      test_op("rand", W'($urandom), W'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset;
    test_op("add_carry8", 32'h0000_00FF, 32'h0000_0001, 1'b0);
    test_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    test_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    test_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1);
    test_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1);
    test_op("sub_zero",   32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1);
    test_ignore_start;
    test_reset_mid_run;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mb_add_seq.md
Name: mb_add_seq

Overview:
- Multi-cycle sequencer that adds or subtracts two NBYTES-wide operands using a single shared 8-bit adder slice, processing one byte per clock, LSB first.
- Holds the inter-byte carry in a register between cycles.
- Sits between the operand switches/registers of the arithmetic datapath and the result display/flag LEDs.
- Trades latency for area: one 8-bit adder is reused instead of a full NBYTES*8 carry chain.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 1..16.

Ports:
- clk     in   1            system clock, rising edge
- rst_n   in   1            asynchronous active-low reset
- start   in   1            request; sampled only in IDLE
- sub     in   1            0 = A+B, 1 = A-B; sampled with start
- a       in   8*NBYTES     operand A; sampled with start
- b       in   8*NBYTES     operand B; sampled with start
- busy    out  1            high while bytes are being processed
- done    out  1            one-cycle pulse; result and flags valid
- result  out  8*NBYTES     sum/difference; held until next accepted start
- co      out  1            carry out of MSB; for sub, 1 = no borrow
- ovf     out  1            signed two's-complement overflow
- zero    out  1            result == 0

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE; busy, done, result, co, ovf, zero, carry register and byte index all 0. Takes effect mid-operation; any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - latch a into opa and (sub ? ~b : b) into opb;
  - carry <= sub; idx <= 0; clear result; state -> RUN.
- IDLE, start=0: stay in IDLE.
- RUN (busy=1), each edge:
  - adder inputs: opa[idx], opb[idx], ci=carry;
  - write result[idx] <= S; carry <= CO;
  - if idx==NBYTES-1, state -> DONE; else idx++.
- Latency: start sampled at edge E0. Bytes are written at edges E1..E_NBYTES. done is high for exactly the cycle after edge E_NBYTES. State returns to IDLE at edge E_NBYTES+1.
- Throughput: one operation per NBYTES+2 cycles.
- DONE (done=1, busy=0):
  - co = final carry;
  - ovf = (opa_msb == opb_msb) && (result_msb != opa_msb), using the already-inverted opb;
  - zero = (result == 0);
  - flags are registered on entry to DONE and held until the next accepted start.
- start while in RUN or DONE is ignored (no queueing). sub, a and b are don't-care outside the start-accept cycle.
- NBYTES=1: single RUN cycle; the same rules apply.
- Subtraction rule: A + ~B + 1. The carry-in of 1 is injected only into byte 0.
- result may show partially updated bytes while busy; consumers sample on done.

Decomposition:
- Shared package arith_pkg:
  - state encoding: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - BYTE_W=8;
  - index width function clog2(NBYTES).
- Sub-module add8_slice: combinational 8-bit adder (A, B, CI -> S, CO) built from full-adder cells, matching the existing gate-level adder.
- mb_add_seq instantiates exactly one add8_slice and owns the FSM, operand registers, carry register and flag logic.

Test Plan (NBYTES=4):
- Reset then idle for 5 cycles -> busy=0, done=0, result=0, co=0, ovf=0, zero=0.
- start, sub=0, A=0x000000FF, B=0x00000001 -> busy for 4 cycles; done pulse 4 cycles after the start edge; result=0x00000100, co=0, ovf=0, zero=0.
- start, sub=0, A=0xFFFFFFFF, B=0x00000001 -> result=0x00000000, co=1, zero=1, ovf=0. Then A=0x7FFFFFFF, B=1 -> result=0x80000000, ovf=1, co=0.
- start, sub=1, A=0x00000005, B=0x00000007 -> result=0xFFFFFFFE, co=0 (borrow), ovf=0. Then A=0x80000000, B=1 -> result=0x7FFFFFFF, co=1, ovf=1.
- Pulse start again during RUN with different operands -> ignored; the first operation's result is unchanged and only one done pulse occurs.
- Drop rst_n during the 2nd RUN cycle -> all outputs 0 immediately, state IDLE. A following start with A=3, B=4 -> result=7 with normal latency.
